// File: rtl/id_pkg.sv
// id_pkg: shared types and constants for the instruction-decode stage.
//   - RV32I major opcode constants
//   - alu_op_t  : ALU operation codes driven to execute
//   - imm_fmt_t : immediate format selector for imm_gen
//   - ctrl_t    : bundle of decoded control signals
//   - RESET_INST_DEFAULT : instruction register value after reset (ADDI x0,x0,0)
package id_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [31:0] RESET_INST_DEFAULT = 32'h0000_0013;

    typedef enum logic [3:0] {
        ALU_ADD,
        ALU_SUB,
        ALU_SLL,
        ALU_SLT,
        ALU_SLTU,
        ALU_XOR,
        ALU_SRL,
        ALU_SRA,
        ALU_OR,
        ALU_AND,
        ALU_SEQ,
        ALU_SNE,
        ALU_SGE,
        ALU_SGEU,
        ALU_PASSB
    } alu_op_t;

    typedef enum logic [2:0] {
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J,
        IMM_NONE
    } imm_fmt_t;

    typedef struct packed {
        logic    branch;
        logic    jump;
        logic    mem_read;
        logic    mem_write;
        logic    reg_write;
        logic    alu_src;
        alu_op_t alu_op;
    } ctrl_t;

    // Arithmetic op for OP / OP-IMM. SUB exists only in the register form;
    // in OP-IMM bit 30 is part of the immediate except for SRAI.
    function automatic alu_op_t arith_op(input logic [2:0] funct3,
                                         input logic       alt,
                                         input logic       is_reg);
        alu_op_t op;
        case (funct3)
            3'b000:  op = (alt && is_reg) ? ALU_SUB : ALU_ADD;
            3'b001:  op = ALU_SLL;
            3'b010:  op = ALU_SLT;
            3'b011:  op = ALU_SLTU;
            3'b100:  op = ALU_XOR;
            3'b101:  op = alt ? ALU_SRA : ALU_SRL;
            3'b110:  op = ALU_OR;
            default: op = ALU_AND;
        endcase
        return op;
    endfunction

    // Branch compare op: execute's flag is asserted exactly when the
    // branch condition holds, so the comparison is named after the condition.
    function automatic alu_op_t branch_op(input logic [2:0] funct3);
        alu_op_t op;
        case (funct3)
            3'b001:  op = ALU_SNE;
            3'b100:  op = ALU_SLT;
            3'b101:  op = ALU_SGE;
            3'b110:  op = ALU_SLTU;
            3'b111:  op = ALU_SGEU;
            default: op = ALU_SEQ;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/id_stage_imm_gen.sv
// imm_gen: combinational immediate generator.
//   inst : instruction bits [31:7] (the opcode field carries no immediate bits)
//   fmt  : immediate format
//   imme : sign-extended byte-offset immediate (0 for IMM_NONE)
module imm_gen
    import id_pkg::*;
(
    input  logic [31:7] inst,
    input  imm_fmt_t    fmt,
    output logic [31:0] imme
);

    always_comb begin
        imme = '0;
        case (fmt)
            IMM_I: imme = {{20{inst[31]}}, inst[31:20]};
            IMM_S: imme = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            IMM_B: imme = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            IMM_U: imme = {inst[31:12], 12'b0};
            IMM_J: imme = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            default: imme = '0;
        endcase
    end

endmodule

// File: rtl/id_stage.sv
// id_stage: instruction-decode stage of the multi-cycle core.
// Starts on IF_kick_up, captures the instruction word one cycle later, and
// presents registered decode results with a one-cycle ID_kick_up token.
//
// Ports:
//   clk, reset (async, active-low)
//   IF_kick_up, inst_mem_read_addr, inst_mem_read_data  - from fetch / imem
//   ID_kick_up, ID_pc, imme, rs1_addr, rs2_addr, rd_addr - to execute
//   Controller_*                                        - decoded controls
//   ID_illegal                                          - sticky illegal-opcode flag
//
// Build option: ID_ILLEGAL_TRAP_EN - when defined, an unsupported opcode sets
// ID_illegal and parks the FSM in DONE without ID_kick_up. When undefined,
// ID_illegal is 0 and unsupported opcodes decode as NOP.
//
// state  | meaning
// -------+-----------------------------------------------------------
// IDLE   | waiting for IF_kick_up
// WAIT   | PC latched, instruction memory read in flight
// DONE   | IR and decoded outputs valid, ID_kick_up asserted (or trapped)
module id_stage
    import id_pkg::*;
#(
    parameter logic [31:0] RESET_INST = RESET_INST_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        IF_kick_up,
    input  logic [31:0] inst_mem_read_addr,
    input  logic [31:0] inst_mem_read_data,
    output logic        ID_kick_up,
    output logic [31:0] ID_pc,
    output logic [31:0] imme,
    output logic [4:0]  rs1_addr,
    output logic [4:0]  rs2_addr,
    output logic [4:0]  rd_addr,
    output logic        Controller_branch,
    output logic        Controller_jump,
    output logic        Controller_mem_read,
    output logic        Controller_mem_write,
    output logic        Controller_reg_write,
    output logic        Controller_alu_src,
    output logic [3:0]  Controller_alu_op,
    output logic        ID_illegal
);

`ifdef ID_ILLEGAL_TRAP_EN
    localparam logic TRAP_EN = 1'b1;
`else
    localparam logic TRAP_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_DONE
    } state_t;

    state_t      state_q,   state_d;
    logic [31:0] pc_q,      pc_d;
    logic [31:0] ir_q,      ir_d;
    logic [31:0] id_pc_q,   id_pc_d;
    logic [31:0] imme_q,    imme_d;
    logic [4:0]  rs1_q,     rs1_d;
    logic [4:0]  rs2_q,     rs2_d;
    logic [4:0]  rd_q,      rd_d;
    ctrl_t       ctrl_q,    ctrl_d;
    logic        kick_q,    kick_d;
    logic        illegal_q, illegal_d;

    ctrl_t       ctrl_dec;
    imm_fmt_t    fmt_dec;
    logic [4:0]  rd_dec;
    logic        illegal_dec;
    logic [31:0] imm_dec;

    // IR loads on the WAIT->DONE edge; decoding ir_d lets the decoded outputs
    // be registered on that same edge.
    assign ir_d = (state_q == S_WAIT) ? inst_mem_read_data : ir_q;

    always_comb begin
        ctrl_dec        = '0;
        ctrl_dec.alu_op = ALU_ADD;
        fmt_dec         = IMM_NONE;
        rd_dec          = ir_d[11:7];
        illegal_dec     = 1'b0;
        case (ir_d[6:0])
            OPC_LUI: begin
                ctrl_dec.reg_write = 1'b1;
                ctrl_dec.alu_src   = 1'b1;
                ctrl_dec.alu_op    = ALU_PASSB;
                fmt_dec            = IMM_U;
            end
            OPC_AUIPC: begin
                ctrl_dec.reg_write = 1'b1;
                ctrl_dec.alu_src   = 1'b1;
                fmt_dec            = IMM_U;
            end
            OPC_JAL: begin
                ctrl_dec.jump      = 1'b1;
                ctrl_dec.reg_write = 1'b1;
                ctrl_dec.alu_src   = 1'b1;
                fmt_dec            = IMM_J;
            end
            OPC_JALR: begin
                ctrl_dec.jump      = 1'b1;
                ctrl_dec.reg_write = 1'b1;
                ctrl_dec.alu_src   = 1'b1;
                fmt_dec            = IMM_I;
            end
            OPC_BRANCH: begin
                ctrl_dec.branch = 1'b1;
                ctrl_dec.alu_op = branch_op(ir_d[14:12]);
                fmt_dec         = IMM_B;
                rd_dec          = '0;
            end
            OPC_LOAD: begin
                ctrl_dec.mem_read  = 1'b1;
                ctrl_dec.reg_write = 1'b1;
                ctrl_dec.alu_src   = 1'b1;
                fmt_dec            = IMM_I;
            end
            OPC_STORE: begin
                ctrl_dec.mem_write = 1'b1;
                ctrl_dec.alu_src   = 1'b1;
                fmt_dec            = IMM_S;
                rd_dec             = '0;
            end
            OPC_OP_IMM: begin
                ctrl_dec.reg_write = 1'b1;
                ctrl_dec.alu_src   = 1'b1;
                ctrl_dec.alu_op    = arith_op(ir_d[14:12], ir_d[30], 1'b0);
                fmt_dec            = IMM_I;
            end
            OPC_OP: begin
                ctrl_dec.reg_write = 1'b1;
                ctrl_dec.alu_op    = arith_op(ir_d[14:12], ir_d[30], 1'b1);
            end
            default: illegal_dec = 1'b1;
        endcase
        // Writes to x0 are discarded here so execute/writeback never see them.
        if (rd_dec == 5'd0) begin
            ctrl_dec.reg_write = 1'b0;
        end
    end

    imm_gen u_imm_gen (
        .inst (ir_d[31:7]),
        .fmt  (fmt_dec),
        .imme (imm_dec)
    );

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        id_pc_d   = id_pc_q;
        imme_d    = imme_q;
        rs1_d     = rs1_q;
        rs2_d     = rs2_q;
        rd_d      = rd_q;
        ctrl_d    = ctrl_q;
        kick_d    = 1'b0;
        illegal_d = illegal_q;
        case (state_q)
            S_IDLE: begin
                if (IF_kick_up) begin
                    state_d = S_WAIT;
                    pc_d    = inst_mem_read_addr;
                end
            end
            S_WAIT: begin
                state_d = S_DONE;
                id_pc_d = pc_q;
                imme_d  = imm_dec;
                rs1_d   = ir_d[19:15];
                rs2_d   = ir_d[24:20];
                rd_d    = rd_dec;
                ctrl_d  = ctrl_dec;
                if (TRAP_EN && illegal_dec) begin
                    illegal_d = 1'b1;
                end else begin
                    kick_d = 1'b1;
                end
            end
            S_DONE: begin
                // A trapped decode parks here until reset.
                if (!illegal_q) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= S_IDLE;
            pc_q      <= '0;
            ir_q      <= RESET_INST;
            id_pc_q   <= '0;
            imme_q    <= '0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            rd_q      <= '0;
            ctrl_q    <= '0;
            kick_q    <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            ir_q      <= ir_d;
            id_pc_q   <= id_pc_d;
            imme_q    <= imme_d;
            rs1_q     <= rs1_d;
            rs2_q     <= rs2_d;
            rd_q      <= rd_d;
            ctrl_q    <= ctrl_d;
            kick_q    <= kick_d;
            illegal_q <= illegal_d;
        end
    end

    assign ID_kick_up           = kick_q;
    assign ID_pc                = id_pc_q;
    assign imme                 = imme_q;
    assign rs1_addr             = rs1_q;
    assign rs2_addr             = rs2_q;
    assign rd_addr              = rd_q;
    assign Controller_branch    = ctrl_q.branch;
    assign Controller_jump      = ctrl_q.jump;
    assign Controller_mem_read  = ctrl_q.mem_read;
    assign Controller_mem_write = ctrl_q.mem_write;
    assign Controller_reg_write = ctrl_q.reg_write;
    assign Controller_alu_src   = ctrl_q.alu_src;
    assign Controller_alu_op    = ctrl_q.alu_op;

`ifdef ID_ILLEGAL_TRAP_EN
    assign ID_illegal = illegal_q;
`else
    assign ID_illegal = 1'b0;
`endif

endmodule
